// File: rtl/french_move_if.sv
// french_move_if: control inputs and position outputs of the french sprite mover.
// Signals: enable, startOfFrame, collision (to mover); ObjectStartX/Y, dir_left, stunned (from mover).
// master = frame/collision source that observes the sprite position, slave = french_move itself.
interface french_move_if;
  logic        enable;
  logic        startOfFrame;
  logic        collision;
  logic [10:0] ObjectStartX;
  logic [10:0] ObjectStartY;
  logic        dir_left;
  logic        stunned;
  modport master (
    output enable, startOfFrame, collision,
    input  ObjectStartX, ObjectStartY, dir_left, stunned
  );
  modport slave (
    input  enable, startOfFrame, collision,
    output ObjectStartX, ObjectStartY, dir_left, stunned
  );
endinterface

// File: rtl/french_move.sv
// french_move: frame-stepped horizontal motion of the french sprite with collision stun.
// Ports: CLK (only clock), RESETn (async active-low reset), bus (french_move_if.slave):
//   enable, startOfFrame, collision in; ObjectStartX/Y, dir_left, stunned out.
// Edges bounce by default; defining FRENCH_MOVE_WRAP_EN makes them wrap around the screen.
module french_move #(
  parameter int INIT_X      = 0,
  parameter int INIT_Y      = 96,
  parameter int SPEED       = 2,
  parameter int STUN_FRAMES = 30,
  parameter int SCREEN_W    = 640,
  parameter int OBJ_W       = 32
) (
  input logic          CLK,
  input logic          RESETn,
  french_move_if.slave bus
);
  localparam logic [11:0] SPD  = 12'(SPEED);
  localparam logic [11:0] XMAX = 12'(SCREEN_W - OBJ_W);
  localparam logic [11:0] SW   = 12'(SCREEN_W);
  typedef enum logic [1:0] {IDLE, MOVE, STUN} state_t;
  state_t      state;
  logic        coll_flag;
  logic [7:0]  stun_cnt;
  logic [10:0] x;
  logic        dir_left;
  logic        stunned;
  logic [11:0] x_ext;
  logic [11:0] sum;
  logic [10:0] x_nxt;
  logic        dir_nxt;
  // Position math is carried at 12 bits so x+SPEED cannot overflow before the edge test.
  assign x_ext = {1'b0, x};
  assign sum   = x_ext + SPD;
`ifdef FRENCH_MOVE_WRAP_EN
  assign x_nxt   = 11'(dir_left ? (x_ext < SPD ? x_ext + SW - SPD : x_ext - SPD)
                                : (sum >= SW ? sum - SW : sum));
  assign dir_nxt = dir_left;
`else
  assign x_nxt   = 11'(dir_left ? (x_ext <= SPD ? 12'd0 : x_ext - SPD)
                                : (sum >= XMAX ? XMAX : sum));
  assign dir_nxt = dir_left ? (x_ext > SPD) : (sum >= XMAX);
`endif
  always_ff @(posedge CLK or negedge RESETn)
    if (!RESETn) begin
      state     <= IDLE;
      coll_flag <= 1'b0;
      stun_cnt  <= '0;
      x         <= 11'(INIT_X);
      dir_left  <= 1'b0;
      stunned   <= 1'b0;
    end else begin
      // A collision on the frame-start cycle belongs to the frame that is starting.
      coll_flag <= bus.collision | (coll_flag & ~bus.startOfFrame);
      if (bus.startOfFrame) begin
        if (!bus.enable) begin
          state    <= IDLE;
          stun_cnt <= '0;
          stunned  <= 1'b0;
        end else begin
          case (state)
            IDLE: state <= MOVE;
            MOVE:
              if (coll_flag) begin
                state    <= STUN;
                stun_cnt <= 8'(STUN_FRAMES - 1);
                stunned  <= 1'b1;
              end else begin
                x        <= x_nxt;
                dir_left <= dir_nxt;
              end
            STUN:
              if (stun_cnt == '0) begin
                state    <= MOVE;
                dir_left <= ~dir_left;
                stunned  <= 1'b0;
              end else
                stun_cnt <= stun_cnt - 8'd1;
            default: state <= IDLE;
          endcase
        end
      end
    end
  assign bus.ObjectStartX = x;
  assign bus.ObjectStartY = 11'(INIT_Y);
  assign bus.dir_left     = dir_left;
  assign bus.stunned      = stunned;
endmodule

// File: tb/tb_french_move.sv
// tb_french_move: directed checks of french_move motion, edges, stun, enable and reset.
module tb_french_move;
  logic CLK = 1'b0;
  logic RESETn = 1'b1;
  logic enable = 1'b0;
  logic sof = 1'b0;
  logic col = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 CLK = ~CLK;
  french_move_if b0 ();
  french_move_if b1 ();
  french_move_if b2 ();
  assign b0.enable = enable;
  assign b0.startOfFrame = sof;
  assign b0.collision = col;
  assign b1.enable = enable;
  assign b1.startOfFrame = sof;
  assign b1.collision = 1'b0;
  assign b2.enable = enable;
  assign b2.startOfFrame = sof;
  assign b2.collision = 1'b0;
  french_move #(.INIT_X(0), .STUN_FRAMES(3)) u0 (.CLK(CLK), .RESETn(RESETn), .bus(b0));
  french_move #(.INIT_X(606))                u1 (.CLK(CLK), .RESETn(RESETn), .bus(b1));
  french_move #(.INIT_X(636))                u2 (.CLK(CLK), .RESETn(RESETn), .bus(b2));
`ifdef FRENCH_MOVE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic st(input string tag, input int x, input int dl, input int s);
    chk({tag, ".x"}, int'(b0.ObjectStartX), x);
    chk({tag, ".dir"}, int'(b0.dir_left), dl);
    chk({tag, ".stun"}, int'(b0.stunned), s);
    chk({tag, ".y"}, int'(b0.ObjectStartY), 96);
  endtask
  task automatic frame();
    @(negedge CLK) sof = 1'b1;
    @(negedge CLK) sof = 1'b0;
    repeat (3) @(negedge CLK);
  endtask
  task automatic pulse_col();
    @(negedge CLK) col = 1'b1;
    @(negedge CLK) col = 1'b0;
    repeat (2) @(negedge CLK);
  endtask
  initial begin
    #2 RESETn = 1'b0;
    @(negedge CLK);
    st("rst", 0, 0, 0);
    chk("rst.u1x", int'(b1.ObjectStartX), 606);
    chk("rst.u2x", int'(b2.ObjectStartX), 636);
    @(negedge CLK);
    RESETn = 1'b1;
    enable = 1'b1;
    frame(); st("f1", 0, 0, 0);
    chk("f1.u1x", int'(b1.ObjectStartX), 606);
    frame(); st("f2", 2, 0, 0);
    chk("f2.u1x", int'(b1.ObjectStartX), 608);
    chk("f2.u1dir", int'(b1.dir_left), WRAP ? 0 : 1);
    chk("f2.u2x", int'(b2.ObjectStartX), WRAP ? 638 : 608);
    frame(); st("f3", 4, 0, 0);
    chk("f3.u1x", int'(b1.ObjectStartX), WRAP ? 610 : 606);
    chk("f3.u2x", int'(b2.ObjectStartX), WRAP ? 0 : 606);
    frame(); st("f4", 6, 0, 0);
    frame(); st("f5", 8, 0, 0);
    frame(); st("f6", 10, 0, 0);
    pulse_col();
    st("f6c", 10, 0, 0);
    frame(); st("f7", 10, 0, 1);
    frame(); st("f8", 10, 0, 1);
    pulse_col();
    frame(); st("f9", 10, 0, 1);
    frame(); st("f10", 10, 1, 0);
    frame(); st("f11", 8, 1, 0);
    @(negedge CLK) begin sof = 1'b1; col = 1'b1; end
    @(negedge CLK) begin sof = 1'b0; col = 1'b0; end
    repeat (3) @(negedge CLK);
    st("f12", 6, 1, 0);
    frame(); st("f13", 6, 1, 1);
    enable = 1'b0;
    frame(); st("f14", 6, 1, 0);
    enable = 1'b1;
    frame(); st("f15", 6, 1, 0);
    frame(); st("f16", 4, 1, 0);
    frame(); st("f17", 2, 1, 0);
    frame(); st("f18", 0, WRAP ? 1 : 0, 0);
    frame(); st("f19", WRAP ? 638 : 2, WRAP ? 1 : 0, 0);
    pulse_col();
    frame(); st("f20", WRAP ? 638 : 2, WRAP ? 1 : 0, 1);
    @(posedge CLK);
    #2 RESETn = 1'b0;
    #1 st("arst", 0, 0, 0);
    frame(); st("rsof", 0, 0, 0);
    @(negedge CLK) RESETn = 1'b1;
    frame(); st("r1", 0, 0, 0);
    frame(); st("r2", 2, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/french_move.md
FRENCH_MOVE -- requirements
Module: french_move

Interface
REQ-001 Parameter INIT_X, default 0, X start coordinate after reset.
REQ-002 Parameter INIT_Y, default 96, Y start coordinate; held constant.
REQ-003 Parameter SPEED, default 2, pixels moved per frame, legal range 1..31.
REQ-004 Parameter STUN_FRAMES, default 30, frames frozen after a collision, legal range 1..255.
REQ-005 Parameters SCREEN_W = 640 and OBJ_W = 32, in pixels.
REQ-006 Port CLK  in  1  system clock; the only clock.
REQ-007 Port RESETn  in  1  reset, asynchronous and active-low.
REQ-008 Port enable  in  1  level; 1 = motion allowed.
REQ-009 Port startOfFrame  in  1  one-cycle pulse, one per VGA frame.
REQ-010 Port collision  in  1  level; french drawing_request overlaps another object this cycle.
REQ-011 Port ObjectStartX  out  11  top-left X, fed to the french draw stage.
REQ-012 Port ObjectStartY  out  11  top-left Y, fed to the french draw stage.
REQ-013 Port dir_left  out  1  1 = moving toward X = 0.
REQ-014 Port stunned  out  1  1 while state is STUN.

Function
REQ-015 All outputs SHALL be registered, and ObjectStartX/Y SHALL change only on the cycle after a startOfFrame pulse, so they stay stable for a whole frame.
REQ-016 The state machine SHALL have three states: IDLE, MOVE and STUN.
REQ-017 IDLE->MOVE SHALL occur at a startOfFrame with enable=1, and no position update occurs in that frame step.
REQ-018 Any state SHALL go to IDLE at a startOfFrame with enable=0, which clears the stun counter and holds the position.
REQ-019 coll_flag SHALL set on any cycle with collision=1 and clear on each startOfFrame pulse.
REQ-020 When collision=1 arrives in the same cycle as startOfFrame, it SHALL count toward the new frame, so coll_flag ends at 1.
REQ-021 In MOVE, a startOfFrame with coll_flag=1 SHALL go to STUN, load the stun counter with STUN_FRAMES-1, and leave the position unchanged.
REQ-022 In MOVE, a startOfFrame with coll_flag=0 SHALL step X by SPEED in the current direction, following REQ-026/027.
REQ-023 In STUN, each startOfFrame SHALL decrement the counter; collisions during STUN are ignored.
REQ-024 At a startOfFrame in STUN with counter=0, the block SHALL toggle dir_left and return to MOVE with no step that frame.
REQ-025 ObjectStartY SHALL always equal INIT_Y.
REQ-026 X arithmetic SHALL be done at 12 bits to avoid overflow, with the result truncated to 11 bits; the limit is XMAX = SCREEN_W-OBJ_W = 608.
REQ-027 Edge handling without the macro is bounce:
- Moving right: if X+SPEED >= XMAX, then X=XMAX and dir_left=1; otherwise X += SPEED.
- Moving left: if X <= SPEED, then X=0 and dir_left=0; otherwise X -= SPEED.
REQ-028 A startOfFrame while RESETn=0 SHALL be ignored.

Reset
REQ-029 While RESETn=0, the block SHALL hold the following values:
- ObjectStartX=INIT_X, ObjectStartY=INIT_Y
- dir_left=0, stunned=0
- state=IDLE, coll_flag=0, stun counter=0
REQ-030 Reset asserted in any state or mid-frame SHALL take effect immediately, with no clock required.
REQ-031 After RESETn deasserts, the first startOfFrame with enable=1 SHALL only enter MOVE.

Configuration
REQ-032 Macro FRENCH_MOVE_WRAP_EN: when defined, edges SHALL wrap instead of bounce, and dir_left never changes at an edge.
- Moving right: if X+SPEED >= SCREEN_W, then X = X+SPEED-SCREEN_W.
- Moving left: if X < SPEED, then X = X+SCREEN_W-SPEED.
REQ-033 When FRENCH_MOVE_WRAP_EN is undefined, the bounce behaviour of REQ-027 SHALL apply, and X SHALL never exceed XMAX.
REQ-034 A collision SHALL still toggle the direction in both builds.

Verification
REQ-035 Normal motion: reset, enable=1, 4 startOfFrame pulses, SPEED=2 -> X sequence 0,0,2,4,6, dir_left=0, ObjectStartY=96 throughout.
REQ-036 Right edge: INIT_X=606, bounce build, in MOVE -> next frame X=608 and dir_left=1, following frame X=606; wrap build -> X=608, then 610, and from X=638 the next frame gives X=0.
REQ-037 Collision stun: collision pulse mid-frame at X=10, STUN_FRAMES=3 -> stunned=1 for 3 frames with X=10 held, then dir_left toggles and X steps to 8 one frame later.
REQ-038 Collision in the same cycle as startOfFrame -> the collision is honoured at the next startOfFrame (STUN entry one frame later); collision during STUN -> no effect on the counter.
REQ-039 Enable drop: enable=0 at the 2nd STUN frame -> IDLE, stunned=0, X held; re-enable -> MOVE with no step, no pending stun.
REQ-040 Asynchronous reset mid-MOVE at X=100, dir_left=1 -> outputs equal INIT_X/INIT_Y/0/0 before the next CLK edge.
